button_conditioner: RTL and testbench

- Upstream input stage for the cursor/paint controller. Conditions the raw board buttons before they reach it.
- Synchronises and debounces the four active-low direction buttons and the paint input.
- Arbitrates the direction buttons by fixed priority and emits single-cycle move strobes with a direction code, including hold-to-repeat.
- The cursor controller consumes move_pulse/move_dir in place of raw button levels; paint_en drives the framebuffer write enable.

---
 rtl/button_conditioner.sv | 170 +++++++++++++++++
 tb/tb_button_conditioner.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - sync/debounce of board buttons, fixed-priority move strobes with hold-to-repeat
// Optional AUTOREPEAT_EN: hold-to-repeat via DELAY/REPEAT states; otherwise one strobe per press (HELD state).
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       up_but,
    input  logic       down_but,
    input  logic       left_but,
    input  logic       right_but,
    input  logic       pintar_but,
    output logic       move_pulse,
    output logic [1:0] move_dir,
    output logic       move_busy,
    output logic       paint_en
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
    // Bit order: 0 up, 1 down, 2 left, 3 right (matches the move_dir code), 4 paint.
    localparam logic [4:0] RELEASED = 5'b0_1111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_REPEAT,
        S_HELD
    } state_t;

    logic [4:0]     w_raw;
    logic [4:0]     r_sync1;
    logic [4:0]     r_sync2;
    logic [4:0]     r_stable;
    logic [DBW-1:0] r_db_cnt [5];
    logic [3:0]     w_pressed;
    logic           w_latched_held;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [1:0]     r_dir;
    logic [1:0]     w_dir_nxt;
    logic           r_pulse;
    logic           w_pulse_nxt;
    logic           r_paint;

    assign w_raw = {pintar_but, right_but, left_but, down_but, up_but};

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            r_sync1  <= RELEASED;
            r_sync2  <= RELEASED;
            r_stable <= RELEASED;
            for (int i = 0; i < 5; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 5; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_stable[i] <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DBW'(1);
                end
            end
        end
    end

    assign w_pressed      = ~r_stable[3:0];
    assign w_latched_held = w_pressed[r_dir];

`ifdef AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW      = $clog2(RPT_MAX);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

    logic [RW-1:0] r_rpt_cnt;
    logic [RW-1:0] w_rpt_cnt_nxt;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_pulse_nxt = 1'b0;
`ifdef AUTOREPEAT_EN
        w_rpt_cnt_nxt = r_rpt_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (|w_pressed) begin
                    if (w_pressed[0])      w_dir_nxt = 2'b00;
                    else if (w_pressed[1]) w_dir_nxt = 2'b01;
                    else if (w_pressed[2]) w_dir_nxt = 2'b10;
                    else                   w_dir_nxt = 2'b11;
                    w_pulse_nxt = 1'b1;
`ifdef AUTOREPEAT_EN
                    w_rpt_cnt_nxt = '0;
                    w_state_nxt   = S_DELAY;
`else
                    w_state_nxt   = S_HELD;
`endif
                end
            end
`ifdef AUTOREPEAT_EN
            // A release seen in the same cycle as a due repeat wins: no strobe.
            S_DELAY: begin
                if (!w_latched_held) begin
                    w_state_nxt = S_IDLE;
                end else if (r_rpt_cnt == DELAY_LAST) begin
                    w_pulse_nxt   = 1'b1;
                    w_rpt_cnt_nxt = '0;
                    w_state_nxt   = S_REPEAT;
                end else begin
                    w_rpt_cnt_nxt = r_rpt_cnt + RW'(1);
                end
            end
            S_REPEAT: begin
                if (!w_latched_held) begin
                    w_state_nxt = S_IDLE;
                end else if (r_rpt_cnt == RATE_LAST) begin
                    w_pulse_nxt   = 1'b1;
                    w_rpt_cnt_nxt = '0;
                end else begin
                    w_rpt_cnt_nxt = r_rpt_cnt + RW'(1);
                end
            end
`else
            S_HELD: begin
                if (!w_latched_held) begin
                    w_state_nxt = S_IDLE;
                end
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_dir   <= 2'b00;
            r_pulse <= 1'b0;
            r_paint <= 1'b0;
`ifdef AUTOREPEAT_EN
            r_rpt_cnt <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_dir   <= w_dir_nxt;
            r_pulse <= w_pulse_nxt;
            r_paint <= r_stable[4];
`ifdef AUTOREPEAT_EN
            r_rpt_cnt <= w_rpt_cnt_nxt;
`endif
        end
    end

    assign move_pulse = r_pulse;
    assign move_dir   = r_dir;
    assign move_busy  = (r_state != S_IDLE);
    assign paint_en   = r_paint;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - scoreboard bench for button_conditioner (DEBOUNCE=4, DELAY=20, RATE=8)
module tb_button_conditioner;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic       up_but, down_but, left_but, right_but, pintar_but;
    logic       move_pulse;
    logic [1:0] move_dir;
    logic       move_busy;
    logic       paint_en;

    typedef struct {
        int         e;
        logic [1:0] d;
    } exp_t;

    exp_t q[$];
    int   edge_n = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   t0;
    logic prev_pulse = 1'b0;

    button_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_RATE    (8)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .up_but    (up_but),
        .down_but  (down_but),
        .left_but  (left_but),
        .right_but (right_but),
        .pintar_but(pintar_but),
        .move_pulse(move_pulse),
        .move_dir  (move_dir),
        .move_busy (move_busy),
        .paint_en  (paint_en)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) edge_n <= edge_n + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic push(input int e, input logic [1:0] d);
        exp_t x;
        x.e = e;
        x.d = d;
        q.push_back(x);
    endtask

    // Pulses are compared against the scoreboard at each falling edge.
    always @(negedge CLOCK_50) begin
        exp_t x;
        if (q.size() > 0 && edge_n > q[0].e) begin
            check("pulse_missing", edge_n, q[0].e);
            x = q.pop_front();
        end
        if (move_pulse === 1'b1) begin
            check("pulse_gap", int'(prev_pulse), 0);
            if (q.size() == 0) begin
                check("pulse_spurious", int'(move_pulse), 0);
            end else begin
                x = q.pop_front();
                check("pulse_edge", edge_n, x.e);
                check("pulse_dir", int'(move_dir), int'(x.d));
            end
        end
        prev_pulse = move_pulse;
    end

    initial begin
        reset = 1'b0;
        up_but = 1'b0; down_but = 1'b0; left_but = 1'b0; right_but = 1'b0;
        pintar_but = 1'b1;
        repeat (3) begin
            @(negedge CLOCK_50);
            check("rst_pulse", int'(move_pulse), 0);
            check("rst_busy", int'(move_busy), 0);
            check("rst_paint", int'(paint_en), 0);
            check("rst_dir", int'(move_dir), 0);
        end
        reset = 1'b1;
        t0 = edge_n;
        push(t0 + 7, 2'b00);
        step(6);
        check("rst_paint_pre", int'(paint_en), 0);
        step(1);
        check("rst_paint_on", int'(paint_en), 1);
        up_but = 1'b1; down_but = 1'b1; left_but = 1'b1; right_but = 1'b1;
        pintar_but = 1'b0;
        step(12);
        check("rst_idle_busy", int'(move_busy), 0);
        check("rst_paint_off", int'(paint_en), 0);

        // tap
        up_but = 1'b0;
        t0 = edge_n;
        push(t0 + 7, 2'b00);
        step(12);
        check("tap_busy_held", int'(move_busy), 1);
        up_but = 1'b1;
        step(6);
        check("tap_busy_before", int'(move_busy), 1);
        step(1);
        check("tap_busy_drop", int'(move_busy), 0);
        step(8);

        // bounce that never settles, then one that settles pressed
        for (int i = 0; i < 6; i++) begin
            right_but = (i % 2 == 1);
            step(2);
        end
        step(12);
        check("bounce_busy", int'(move_busy), 0);
        for (int i = 0; i < 6; i++) begin
            right_but = (i % 2 == 1);
            step(2);
        end
        right_but = 1'b0;
        t0 = edge_n;
        push(t0 + 7, 2'b11);
        step(10);
        right_but = 1'b1;
        step(12);

        // hold
        down_but = 1'b0;
        t0 = edge_n;
        push(t0 + 7, 2'b01);
`ifdef AUTOREPEAT_EN
        for (int k = 0; k < 5; k++) push(t0 + 27 + 8 * k, 2'b01);
`endif
        step(60);
        down_but = 1'b1;
        step(12);
        check("hold_busy_end", int'(move_busy), 0);

        // priority and latching
        left_but = 1'b0; up_but = 1'b0;
        t0 = edge_n;
        push(t0 + 7, 2'b00);
        step(8);
        up_but = 1'b1;
        step(7);
        check("pri_busy_drop", int'(move_busy), 0);
        push(t0 + 16, 2'b10);
        step(3);
        up_but = 1'b0;
        step(7);
        check("pri_latched_dir", int'(move_dir), 2);
        check("pri_latched_busy", int'(move_busy), 1);
        step(1);
        up_but = 1'b1; left_but = 1'b1;
        step(14);
        check("pri_idle_busy", int'(move_busy), 0);
        check("pri_dir_hold", int'(move_dir), 2);

        // paint
        pintar_but = 1'b1;
        step(3);
        pintar_but = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            check("paint_glitch", int'(paint_en), 0);
        end
        pintar_but = 1'b1;
        t0 = edge_n;
        step(6);
        check("paint_pre", int'(paint_en), 0);
        step(1);
        check("paint_on", int'(paint_en), 1);
        step(3);
        pintar_but = 1'b0;
        step(6);
        check("paint_still_on", int'(paint_en), 1);
        step(1);
        check("paint_off", int'(paint_en), 0);

        // reset during a hold
        left_but = 1'b0;
        t0 = edge_n;
        push(t0 + 7, 2'b10);
        step(10);
        reset = 1'b0;
        step(1);
        check("midrst_busy", int'(move_busy), 0);
        check("midrst_dir", int'(move_dir), 0);
        step(1);
        reset = 1'b1;
        t0 = edge_n;
        push(t0 + 7, 2'b10);
        step(8);
        left_but = 1'b1;
        step(12);
        check("midrst_idle", int'(move_busy), 0);

        step(2);
        check("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
